// File: rtl/motor_pwm_drive.sv
// Dual-side H-bridge PWM driver: per-side STOP/BRAKE/DEAD/RUN control with duty ramping
// and dead time on direction reversal, driven from one shared PWM counter.
module motor_pwm_drive #(
  parameter int PWM_MAX   = 249,
  parameter int DUTY_TGT  = 200,
  parameter int RAMP_STEP = 10,
  parameter int DEAD_CYC  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor,
  output logic [3:0] pwm_out,
  output logic [1:0] at_speed
);

  // Duty must hold PWM_MAX+1 (always-on), so size it one count beyond the counter range.
  localparam int CW  = $clog2(PWM_MAX + 2);
  localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [CW-1:0]  CNT_MAX = CW'(PWM_MAX);
  localparam logic [CW-1:0]  DUTY_T  = CW'(DUTY_TGT);
  localparam logic [CW-1:0]  STEP    = CW'(RAMP_STEP);
  localparam logic [DCW-1:0] DEAD_LD = DCW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DEAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  logic [3:0]    cmd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap  = (cnt_q == CNT_MAX);
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      cnt_q <= '0;
    end else begin
      cmd_q <= motor;
      cnt_q <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      state_e         state_q, state_d;
      logic           dir_q, dir_d;
      logic [CW-1:0]  duty_q, duty_d;
      logic [DCW-1:0] dead_q, dead_d;
      logic [CW:0]    duty_sum;
      logic [1:0]     side_cmd;
      logic           cmd_dir;
      logic [1:0]     leg_q, leg_d;
      logic           as_q, as_d;

      assign side_cmd = cmd_q[2*gi +: 2];
      assign cmd_dir  = side_cmd[1];
      assign duty_sum = {1'b0, duty_q} + {1'b0, STEP};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_STOP;
          dir_q   <= 1'b1;
          duty_q  <= '0;
          dead_q  <= '0;
          leg_q   <= 2'b00;
          as_q    <= 1'b0;
        end else begin
          state_q <= state_d;
          dir_q   <= dir_d;
          duty_q  <= duty_d;
          dead_q  <= dead_d;
          leg_q   <= leg_d;
          as_q    <= as_d;
        end
      end

      always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        case (side_cmd)
          2'b00: begin
            state_d = ST_STOP;
            duty_d  = '0;
            dead_d  = '0;
          end
          2'b11: begin
            state_d = ST_BRAKE;
            duty_d  = '0;
            dead_d  = '0;
          end
          default: begin
            case (state_q)
              ST_RUN: begin
                if (cmd_dir != dir_q) begin
                  state_d = ST_DEAD;
                  dir_d   = cmd_dir;
                  duty_d  = '0;
                  dead_d  = DEAD_LD;
                end else if (wrap) begin
                  duty_d = (duty_sum > {1'b0, DUTY_T}) ? DUTY_T : duty_sum[CW-1:0];
                end
              end
              ST_DEAD: begin
                if (cmd_dir != dir_q) begin
                  dir_d  = cmd_dir;
                  dead_d = DEAD_LD;
                end else if (dead_q == '0) begin
                  // Entry always starts at zero duty, even on a wrap edge.
                  state_d = ST_RUN;
                  duty_d  = '0;
                end else begin
                  dead_d = dead_q - DCW'(1);
                end
              end
              default: begin
                state_d = ST_RUN;
                dir_d   = cmd_dir;
                duty_d  = '0;
                dead_d  = '0;
              end
            endcase
          end
        endcase

        // Outputs registered from next state so they move on the same edge as the FSM.
        leg_d = 2'b00;
        if (state_d == ST_BRAKE) begin
          leg_d = 2'b11;
        end else if (state_d == ST_RUN && cnt_d < duty_d) begin
          leg_d = dir_d ? 2'b10 : 2'b01;
        end
        as_d = (state_d == ST_RUN) && (duty_d == DUTY_T);
      end

      assign pwm_out[2*gi +: 2] = leg_q;
      assign at_speed[gi]       = as_q;
    end
  endgenerate

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive with small parameters: ramp, reversal dead time,
// dead-window reload, brake/coast latency, mid-ramp reset and a command-sequence checker.
module tb_motor_pwm_drive;

  logic       clk;
  logic       rst_n;
  logic [3:0] motor;
  logic [3:0] pwm_out;
  logic [1:0] at_speed;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt;
  logic [3:0] m1, m2;

  motor_pwm_drive #(
    .PWM_MAX  (9),
    .DUTY_TGT (8),
    .RAMP_STEP(3),
    .DEAD_CYC (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .motor   (motor),
    .pwm_out (pwm_out),
    .at_speed(at_speed)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference PWM counter and the two-edge command pipeline seen by the FSMs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_cnt <= 0;
      m1     <= 4'b0000;
      m2     <= 4'b0000;
    end else begin
      tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
      m1     <= motor;
      m2     <= m1;
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic align(input int v);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (tb_cnt != v && guard < 30);
    n_checks++;
    if (tb_cnt != v) begin
      n_fail++;
      $display("FAIL align: counter phase %0d required %0d", tb_cnt, v);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
    end
    n_checks++;
    if (at_speed !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_at_speed: got %b expected 00", at_speed);
    end
    $display("test_reset: pwm_out=%b at_speed=%b", pwm_out, at_speed);
  endtask

  // Releases reset with motor=1010 held and measures high time per full PWM period.
  task automatic test_ramp(input int nwin);
    int exp_hi[4] = '{3, 6, 8, 8};
    int hi3, hi1, lo;
    logic [1:0] exp_as;
    rst_n = 1'b1;
    align(9);
    for (int w = 0; w < nwin; w++) begin
      hi3 = 0; hi1 = 0; lo = 0;
      for (int s = 0; s < 10; s++) begin
        @(negedge clk);
        if (s == 0) begin
          exp_as = (w >= 2) ? 2'b11 : 2'b00;
          n_checks++;
          if (at_speed !== exp_as) begin
            n_fail++;
            $display("FAIL ramp_at_speed: period %0d got %b expected %b", w, at_speed, exp_as);
          end
        end
        hi3 += int'(pwm_out[3]);
        hi1 += int'(pwm_out[1]);
        lo  += int'(pwm_out[2]) + int'(pwm_out[0]);
      end
      n_checks++;
      if (hi3 != exp_hi[w] || hi1 != exp_hi[w] || lo != 0) begin
        n_fail++;
        $display("FAIL ramp_duty: period %0d got left=%0d right=%0d rev=%0d expected %0d/%0d/0",
                 w, hi3, hi1, lo, exp_hi[w], exp_hi[w]);
      end
      $display("test_ramp: period %0d high left=%0d right=%0d", w, hi3, hi1);
    end
  endtask

  task automatic test_reverse;
    logic [1:0] exp_l, exp_r, exp_as;
    align(4);
    motor = 4'b0110;
    for (int j = 1; j <= 35; j++) begin
      @(negedge clk);
      if (j == 1)      exp_l = {tb_cnt < 8, 1'b0};
      else if (j < 16) exp_l = 2'b00;
      else if (j < 26) exp_l = {1'b0, tb_cnt < 3};
      else             exp_l = {1'b0, tb_cnt < 6};
      exp_r  = {tb_cnt < 8, 1'b0};
      exp_as = {j == 1, 1'b1};
      n_checks++;
      if (pwm_out !== {exp_l, exp_r} || at_speed !== exp_as) begin
        n_fail++;
        $display("FAIL reverse: step %0d got pwm=%b as=%b expected pwm=%b as=%b",
                 j, pwm_out, at_speed, {exp_l, exp_r}, exp_as);
      end
      n_checks++;
      if (pwm_out[3] && pwm_out[2]) begin
        n_fail++;
        $display("FAIL reverse_shoot: step %0d got pwm=%b expected no 11 on left", j, pwm_out);
      end
    end
    $display("test_reverse: done");
  endtask

  task automatic test_dead_reload;
    logic [1:0] exp_l, exp_r, exp_as;
    align(0);
    motor = 4'b1010;
    for (int j = 1; j <= 29; j++) begin
      @(negedge clk);
      if (j == 1)      exp_l = {1'b0, tb_cnt < 8};
      else if (j < 20) exp_l = 2'b00;
      else             exp_l = {tb_cnt < 3, 1'b0};
      exp_r  = {tb_cnt < 8, 1'b0};
      exp_as = (j == 1) ? 2'b11 : 2'b01;
      n_checks++;
      if (pwm_out !== {exp_l, exp_r} || at_speed !== exp_as) begin
        n_fail++;
        $display("FAIL dead_reload: step %0d got pwm=%b as=%b expected pwm=%b as=%b",
                 j, pwm_out, at_speed, {exp_l, exp_r}, exp_as);
      end
      if (j == 2) motor = 4'b0110;
      if (j == 4) motor = 4'b1010;
    end
    $display("test_dead_reload: done");
  endtask

  task automatic test_brake;
    motor = 4'b1111;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (j == 1) begin
        if (pwm_out === 4'b1111) begin
          n_fail++;
          $display("FAIL brake_latency: step 1 got %b expected not 1111", pwm_out);
        end
      end else if (pwm_out !== 4'b1111 || at_speed !== 2'b00) begin
        n_fail++;
        $display("FAIL brake: step %0d got pwm=%b as=%b expected 1111/00", j, pwm_out, at_speed);
      end
    end
    motor = 4'b0000;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      n_checks++;
      if (j == 1) begin
        if (pwm_out !== 4'b1111) begin
          n_fail++;
          $display("FAIL coast_latency: step 1 got %b expected 1111", pwm_out);
        end
      end else if (pwm_out !== 4'b0000 || at_speed !== 2'b00) begin
        n_fail++;
        $display("FAIL coast: step %0d got pwm=%b as=%b expected 0000/00", j, pwm_out, at_speed);
      end
    end
    $display("test_brake: done");
  endtask

  task automatic test_reset_mid;
    align(0);
    motor = 4'b1010;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 9) begin
        n_checks++;
        if (pwm_out !== 4'b0000) begin
          n_fail++;
          $display("FAIL midreset_pre0: got %b expected 0000", pwm_out);
        end
      end
      if (j == 10) begin
        n_checks++;
        if (pwm_out !== 4'b1010) begin
          n_fail++;
          $display("FAIL midreset_pre: got %b expected 1010", pwm_out);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pwm_out !== 4'b0000 || at_speed !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_async: got pwm=%b as=%b expected 0000/00", pwm_out, at_speed);
    end
    $display("test_reset_mid: pwm_out=%b during reset", pwm_out);
    repeat (2) @(negedge clk);
    test_ramp(2);
  endtask

  task automatic test_sequence;
    logic [3:0] tbl[10] = '{4'b0101, 4'b1001, 4'b0110, 4'b1111, 4'b0110,
                            4'b0000, 4'b1001, 4'b0110, 4'b0111, 4'b1011};
    logic [3:0] prev;
    logic [1:0] cur, prv, out;
    int rev_t[2] = '{0, 0};
    prev = m2;
    for (int i = 0; i < 10; i++) begin
      motor = tbl[i];
      repeat (5) begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
          cur = m2[2*s +: 2];
          prv = prev[2*s +: 2];
          out = pwm_out[2*s +: 2];
          if ((cur[1] ^ cur[0]) && (prv[1] ^ prv[0]) && cur != prv) rev_t[s] = 4;
          n_checks++;
          if ((out == 2'b11) != (cur == 2'b11)) begin
            n_fail++;
            $display("FAIL seq_legs: side %0d got %b with cmd %b", s, out, cur);
          end
          if (rev_t[s] > 0) begin
            n_checks++;
            if (out !== 2'b00) begin
              n_fail++;
              $display("FAIL seq_dead: side %0d got %b expected 00", s, out);
            end
            rev_t[s]--;
          end
          if (cur == 2'b00) begin
            n_checks++;
            if (out !== 2'b00) begin
              n_fail++;
              $display("FAIL seq_stop: side %0d got %b expected 00", s, out);
            end
          end
        end
        prev = m2;
      end
      $display("test_sequence: cmd %0d = %b pwm_out=%b", i, tbl[i], pwm_out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    motor = 4'b1010;
    test_reset;
    test_ramp(4);
    test_reverse;
    test_dead_reload;
    test_brake;
    test_reset_mid;
    test_sequence;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
